// File: rtl/seq_twos_complement_divider.sv
// Sequential 16-bit radix-2 restoring divider with signed/unsigned modes.
// The divider works on operand magnitudes. It runs one shift/subtract/restore
// step per clock and then spends one clock negating the quotient and remainder
// as needed. The results are held in DONE until the next start is accepted.
module seq_twos_complement_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;        // partial remainder
  logic [WIDTH-1:0] quo_q;        // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q;        // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;

  // Operand magnitudes and the trial subtraction for one restoring step.
  // NOTE: combinational logic uses blocking '=' with every output assigned on
  // every path; clocked state below uses non-blocking '<=' only.
  always_comb begin
    dvd_mag_d = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag_d = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    // The shifted remainder is less than 2*|divisor|. A WIDTH+1-bit difference
    // therefore has its MSB set exactly when the trial goes negative.
    trial_d   = shifted_d - {1'b0, dvs_q};
  end

  // Control FSM and datapath registers with registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset along with the control state, so
    // that an aborted operation leaves nothing visible and lint sees no X source.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero completes immediately and does not disturb the datapath.
              state_q     <= S_DONE;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= S_DIV;
              q_neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_q <= signed_op & dividend[WIDTH-1];
              rem_q   <= '0;
              quo_q   <= dvd_mag_d;
              dvs_q   <= dvs_mag_d;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end

        S_DIV: begin
          if (trial_d[WIDTH]) begin
            // The trial went negative, so restore the remainder and shift in a 0.
            rem_q <= shifted_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_q <= trial_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          // Restore the signs. -32768 / -1 wraps to 16'h8000 naturally.
          quotient_q  <= q_neg_q ? -quo_q : quo_q;
          remainder_q <= r_neg_q ? -rem_q : rem_q;
          dbz_q       <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule

// File: tb/tb_seq_twos_complement_divider.sv
// Scoreboard bench for seq_twos_complement_divider. The stimulus pushes the
// expected results, and a monitor pops and compares them when an accepted
// operation presents done.
module tb_seq_twos_complement_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_twos_complement_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: note each accepted start, then compare once done presents that result.
  initial begin
    bit pending = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) pending = 1'b0;
      else if (start && !busy) pending = 1'b1;
      @(negedge clk);
      if (pending && done) begin
        pending = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, " quotient"},    quotient,    e.q);
          check({e.name, " remainder"},   remainder,   e.r);
          check({e.name, " div_by_zero"}, div_by_zero, e.dbz);
        end
      end
    end
  end

  // Issue one operation from IDLE/DONE. The caller is at #1 after a rising edge.
  // inject_at pulses a different start mid-operation. abort_at applies reset mid-operation.
  task automatic run_op(input string name, input bit s, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [15:0] r, input bit dbz,
                        input int exp_lat, input int exp_busy, input int inject_at, input int abort_at);
    exp_t e;
    int   lat;
    int   busy_cnt;
    e.name = name; e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    signed_op = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs to show that the operands were latched.
    dividend = 16'h5A5A; divisor = 16'h0003; signed_op = ~s;
    busy_cnt = busy ? 1 : 0;
    if (exp_busy != 0) check({name, " done_low_after_accept"}, done, 1'b0);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n == inject_at) begin
        start = 1'b1; dividend = 16'd7; divisor = 16'd7;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check({name, " abort busy"},        busy,        1'b0);
        check({name, " abort done"},        done,        1'b0);
        check({name, " abort div_by_zero"}, div_by_zero, 1'b0);
        check({name, " abort quotient"},    quotient,    16'h0000);
        check({name, " abort remainder"},   remainder,   16'h0000);
        void'(sb.pop_back());
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({name, " latency"},     lat,      exp_lat);
    check({name, " busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",        busy,        1'b0);
    check("reset done",        done,        1'b0);
    check("reset div_by_zero", div_by_zero, 1'b0);
    check("reset quotient",    quotient,    16'h0000);
    check("reset remainder",   remainder,   16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     name          sgn  dividend  divisor   quotient  remainder dbz lat busy inj abort
    run_op("u100_7",     0,   16'd100,  16'd7,    16'h000E, 16'h0002, 0,  17, 17,  0,  0);
    run_op("s-100_7",    1,   16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 0,  17, 17,  0,  0);
    run_op("s100_-7",    1,   16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 0,  17, 17,  0,  0);
    run_op("dbz1234",    0,   16'd1234, 16'h0000, 16'hFFFF, 16'h04D2, 1,  1,  0,   0,  0);
    run_op("s_min_-1",   1,   16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0,  17, 17,  0,  0);
    run_op("uFFFF_1",    0,   16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0,  17, 17,  0,  0);
    run_op("u5_9",       0,   16'd5,    16'd9,    16'h0000, 16'h0005, 0,  17, 17,  0,  0);
    run_op("s_min_7",    1,   16'h8000, 16'h0007, 16'hEDB7, 16'hFFFF, 0,  17, 17,  0,  0);
    run_op("u1000_3_inj",0,   16'd1000, 16'd3,    16'h014D, 16'h0001, 0,  17, 17,  5,  0);
    run_op("u200_10_b2b",0,   16'd200,  16'd10,   16'h0014, 16'h0000, 0,  17, 17,  0,  0);
    run_op("u5000_3_rst",0,   16'd5000, 16'd3,    16'h0682, 16'h0002, 0,  17, 17,  0,  8);
    run_op("u1000_10",   0,   16'd1000, 16'd10,   16'h0064, 16'h0000, 0,  17, 17,  0,  0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
